or_gate: RTL and testbench
==========================

// Module: or_gate
// PURPOSE
//   Two-input logical OR, the base Hack gate above Nand/Not in the gate library.
//   out = a | b is purely combinational and settles within one delta of any input change, with no clock needed.
//   A clocked side path adds a registered copy of the result and optional usage statistics for board-level debug.
//   Consumers needing a glitch-free, cycle-aligned value use out_q.
// PARAMETERS
//   CNT_W    16   width of each statistics counter (min 2)
// PORTS
//   clk        in   1        single system clock, rising-edge active
//   rst_n      in   1        reset, synchronous to clk, active-low
//   a          in   1        operand A
//   b          in   1        operand B
//   out        out  1        combinational a|b, independent of clk/rst_n
//   out_q      out  1        a|b registered on clk
//   rise       out  1        one-cycle pulse: out_q went 0->1 this cycle
//   hi_cnt     out  CNT_W    cycles sampled with a|b==1 (stats build only)
//   rise_cnt   out  CNT_W    number of rise pulses (stats build only)
// BEHAVIOUR
//   - out: full truth table, 00->0, 01->1, 10->1, 11->1.
//     - No storage on this path.
//     - Valid during reset and with clk stopped.
//   - Interface: one clock and one reset; reset is synchronous and active-low.
//   - Reset: on a clk edge with rst_n=0, outputs take these values.
//     - out_q=0, rise=0, hi_cnt=0, rise_cnt=0.
//     - out is unaffected by reset.
//   - Latency: out_q = value of a|b sampled at the previous rising edge (1 cycle).
//   - rise is registered and is 1 for exactly one cycle, in the cycle after the edge where a|b=1 and out_q was 0.
//   - First sample after reset release with a|b=1 produces rise=1, since out_q resets to 0.
//   - hi_cnt increments by 1 on each edge where rst_n=1 and a|b=1.
//   - rise_cnt increments by 1 on each edge where a rise is generated.
//   - Counters saturate at 2^CNT_W-1 and never wrap.
//   - Reset asserted mid-count clears counters on that same edge; reset has priority over increments.
//   - Inputs X/Z: out follows Verilog | semantics; no X-trapping logic.
// CONFIGURATION
//   OR_STATS_EN defined:
//     - hi_cnt and rise_cnt are implemented as described above.
//   OR_STATS_EN undefined:
//     - hi_cnt and rise_cnt are tied to 0.
//     - No counter flops are inferred.
//     - Ports remain present so instantiations are identical.
//   out, out_q and rise are identical in both builds.
// TESTING
//   1. Sweep a,b = 00,01,10,11 with 1 time-unit settle each, no clock -> out = 0,1,1,1.
//   2. Hold rst_n=0 for 2 clks with a=1,b=1 -> out=1, out_q=0, rise=0, hi_cnt=0, rise_cnt=0.
//   3. Release reset, drive a=0,b=1 for 3 clks -> out_q=1 from the 1st edge on, rise=1 only in the first cycle.
//      - With OR_STATS_EN: hi_cnt=3, rise_cnt=1.
//   4. Toggle a 1,0,1,0 with b=0 -> out_q alternates.
//      - rise pulses twice.
//      - With OR_STATS_EN: rise_cnt=+2, hi_cnt=+2.
//   5. CNT_W=2, a=1 for 6 clks -> hi_cnt saturates at 3.
//      - Then rst_n=0 for one edge -> all counters 0 on that edge.
//   6. Rebuild without OR_STATS_EN, repeat test 3 -> hi_cnt=rise_cnt=0; out/out_q/rise unchanged.

Source files
------------

// File: rtl/or_gate.sv
// ---------------------------------------------------------------------------
// or_gate
//   Two-input logical OR, the base Hack gate above Nand/Not.
//   - out      : purely combinational a|b. No storage, valid with clk stopped
//                and while rst_n is low.
//   - out_q    : a|b registered on the rising edge of clk (1-cycle latency).
//   - rise     : registered one-cycle pulse, set on an edge where a|b=1 and
//                out_q was 0.
//   - hi_cnt   : saturating count of edges sampled with a|b=1.
//   - rise_cnt : saturating count of generated rise pulses.
//   The two statistics counters exist only when OR_STATS_EN is defined.
//   Otherwise they are tied to zero and no counter flops are built. The
//   ports remain present, so instantiations do not change between builds.
//   Reset is synchronous and active-low. Reset takes priority over every
//   increment.
// ---------------------------------------------------------------------------
module or_gate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             out,
    output logic             out_q,
    output logic             rise,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] rise_cnt
);

    // Combined operand value, shared by the combinational and clocked paths.
    logic or_s;
    // Condition that produces a rise pulse on the next edge.
    logic rise_set_s;

    assign or_s       = a | b;
    assign rise_set_s = or_s & ~out_q;

    // The combinational output follows the operands directly. Reset and the
    // clock do not touch it.
    assign out = or_s;

    // Registered copy of the OR result and its 0->1 edge pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            out_q <= or_s;
            rise  <= rise_set_s;
        end
    end

`ifdef OR_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment. A counter at full scale holds its value and
    // never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = CNT_MAX;
        end else begin
            res = val + CNT_ONE;
        end
        return res;
    endfunction

    // Count the edges sampled with a|b high. Reset wins over the increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt <= CNT_ZERO;
        end else if (or_s) begin
            hi_cnt <= sat_inc(hi_cnt);
        end else begin
            hi_cnt <= hi_cnt;
        end
    end

    // Count the rise pulses on the same edge that generates each pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_cnt <= CNT_ZERO;
        end else if (rise_set_s) begin
            rise_cnt <= sat_inc(rise_cnt);
        end else begin
            rise_cnt <= rise_cnt;
        end
    end
`else
    // The statistics are not built, so the ports read as constant zero.
    assign hi_cnt   = {CNT_W{1'b0}};
    assign rise_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_or_gate.sv
// ---------------------------------------------------------------------------
// tb_or_gate
//   Directed, table-driven bench for or_gate. The first instance uses the
//   default counter width. A second instance with CNT_W=2 shares the same
//   stimulus and exercises counter saturation. The expected counter values
//   depend on whether OR_STATS_EN is defined for this build.
// ---------------------------------------------------------------------------
module tb_or_gate;

`ifdef OR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        out;
    logic        out_q;
    logic        rise;
    logic [15:0] hi_cnt;
    logic [15:0] rise_cnt;
    logic        out2;
    logic        out_q2;
    logic        rise2;
    logic [1:0]  hi_cnt2;
    logic [1:0]  rise_cnt2;

    int errors;
    int checks;

    or_gate #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .out      (out),
        .out_q    (out_q),
        .rise     (rise),
        .hi_cnt   (hi_cnt),
        .rise_cnt (rise_cnt)
    );

    or_gate #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .out      (out2),
        .out_q    (out_q2),
        .rise     (rise2),
        .hi_cnt   (hi_cnt2),
        .rise_cnt (rise_cnt2)
    );

    // Clock generator, gated so that the combinational sweep runs with no clock.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic a;
        logic b;
        logic exp_out;
    } comb_vec_t;

    // Counter expectations are given for the stats build.
    typedef struct {
        logic rst_n;
        logic a;
        logic b;
        logic exp_q;
        logic exp_rise;
        int   exp_hi;
        int   exp_rc;
    } clk_vec_t;

    comb_vec_t comb_tbl [4];
    clk_vec_t  clk_tbl  [14];

    initial begin
        errors = 0;
        checks = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a      = 1'b0;
        b      = 1'b0;

        comb_tbl[0] = '{1'b0, 1'b0, 1'b0};
        comb_tbl[1] = '{1'b0, 1'b1, 1'b1};
        comb_tbl[2] = '{1'b1, 1'b0, 1'b1};
        comb_tbl[3] = '{1'b1, 1'b1, 1'b1};

        //               rst   a     b     q     rise  hi  rc
        clk_tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0}; // hold reset
        clk_tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        clk_tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1}; // first sample rises
        clk_tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1};
        clk_tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1};
        clk_tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1}; // drop low
        clk_tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4, 2}; // toggle a
        clk_tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 2};
        clk_tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5, 3};
        clk_tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 3};
        clk_tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6, 4};
        clk_tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0}; // mid-count reset
        clk_tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1};
        clk_tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1};

        // Combinational sweep with the clock stopped and reset asserted.
        for (int i = 0; i < 4; i++) begin
            a = comb_tbl[i].a;
            b = comb_tbl[i].b;
            #1;
            check($sformatf("comb_out[%0d]", i), {31'd0, out}, {31'd0, comb_tbl[i].exp_out});
        end

        // Clocked table. Inputs change 1 unit after an edge and are checked
        // 1 unit after the next edge.
        clk_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rst_n = clk_tbl[i].rst_n;
            a     = clk_tbl[i].a;
            b     = clk_tbl[i].b;
            @(posedge clk);
            #1;
            check($sformatf("out[%0d]", i), {31'd0, out}, {31'd0, clk_tbl[i].a | clk_tbl[i].b});
            check($sformatf("out_q[%0d]", i), {31'd0, out_q}, {31'd0, clk_tbl[i].exp_q});
            check($sformatf("rise[%0d]", i), {31'd0, rise}, {31'd0, clk_tbl[i].exp_rise});
            check($sformatf("hi_cnt[%0d]", i), {16'd0, hi_cnt},
                  STATS ? clk_tbl[i].exp_hi : 32'd0);
            check($sformatf("rise_cnt[%0d]", i), {16'd0, rise_cnt},
                  STATS ? clk_tbl[i].exp_rc : 32'd0);
        end

        // Saturation on the 2-bit instance. It holds hi=2, rc=1 from the
        // table and out_q=1, so no new rise occurs.
        for (int k = 0; k < 6; k++) begin
            rst_n = 1'b1;
            a     = 1'b1;
            b     = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("sat_hi[%0d]", k), {30'd0, hi_cnt2}, STATS ? 32'd3 : 32'd0);
            check($sformatf("sat_rc[%0d]", k), {30'd0, rise_cnt2}, STATS ? 32'd1 : 32'd0);
            check($sformatf("sat_q[%0d]", k), {31'd0, out_q2}, 32'd1);
        end

        // A single reset edge clears everything, and out keeps following a|b.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hi2", {30'd0, hi_cnt2}, 32'd0);
        check("rst_rc2", {30'd0, rise_cnt2}, 32'd0);
        check("rst_q2", {31'd0, out_q2}, 32'd0);
        check("rst_rise2", {31'd0, rise2}, 32'd0);
        check("rst_hi", {16'd0, hi_cnt}, 32'd0);
        check("rst_out", {31'd0, out}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
